// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cache_mem_arbiter : round-robin share of one burst memory port by icache/dcache
// Rev 1.0
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
   parameter int LINE_WIDTH = 256,
   parameter int BEAT_WIDTH = 64,
   parameter int BURST_LEN  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           i_dfp_addr,
   input  logic                  i_dfp_read,
   output logic [LINE_WIDTH-1:0] i_dfp_rdata,
   output logic                  i_dfp_resp,
   input  logic [31:0]           d_dfp_addr,
   input  logic                  d_dfp_read,
   input  logic                  d_dfp_write,
   input  logic [LINE_WIDTH-1:0] d_dfp_wdata,
   output logic [LINE_WIDTH-1:0] d_dfp_rdata,
   output logic                  d_dfp_resp,
   output logic [31:0]           bmem_addr,
   output logic                  bmem_read,
   output logic                  bmem_write,
   output logic [BEAT_WIDTH-1:0] bmem_wdata,
   input  logic                  bmem_ready,
   input  logic [BEAT_WIDTH-1:0] bmem_rdata,
   input  logic                  bmem_rvalid
);
   localparam int            CW        = $clog2(BURST_LEN) + 1;
   localparam int            OFS       = $clog2(LINE_WIDTH / 8);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
   localparam logic          ICACHE    = 1'b0;
   localparam logic          DCACHE    = 1'b1;

   typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RESP} state_t;

   state_t                state;
   logic [CW-1:0]         count;
   logic                  last_grant;
   logic                  owner;
   logic [31:0]           addr_q;
   logic [LINE_WIDTH-1:0] line_buf;
   logic [LINE_WIDTH-1:0] line_next;
   logic [LINE_WIDTH-1:0] i_rdata_q;
   logic [LINE_WIDTH-1:0] d_rdata_q;

   logic                  i_req;
   logic                  d_req;
   logic                  pick_d;
   logic                  go;
   logic                  go_write;
   logic [31:0]           sel_addr;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^{i_dfp_addr[OFS-1:0], d_dfp_addr[OFS-1:0]};

   // A grant only takes effect in a cycle where memory can accept the command.
   always_comb begin
      i_req     = i_dfp_read;
      d_req     = d_dfp_read | d_dfp_write;
      pick_d    = d_req && (!i_req || (last_grant == ICACHE));
      go        = rst_n && (state == IDLE) && (i_req || d_req) && bmem_ready;
      go_write  = go && pick_d && d_dfp_write;
      sel_addr  = pick_d ? {d_dfp_addr[31:OFS], OFS'(0)} : {i_dfp_addr[31:OFS], OFS'(0)};
      line_next = line_buf;
      line_next[count*BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
   end

   always_comb begin
      bmem_read  = go && !go_write;
      bmem_write = go_write || (state == WR_BURST);
      bmem_addr  = '0;
      if (go)
         bmem_addr = sel_addr;
      else if ((state == WR_BURST) || (state == RD_WAIT))
         bmem_addr = addr_q;
      bmem_wdata = '0;
      if (go_write)
         bmem_wdata = d_dfp_wdata[BEAT_WIDTH-1:0];
      else if (state == WR_BURST)
         bmem_wdata = d_dfp_wdata[count*BEAT_WIDTH +: BEAT_WIDTH];
      i_dfp_resp  = (state == RESP) && (owner == ICACHE);
      d_dfp_resp  = (state == RESP) && (owner == DCACHE);
      i_dfp_rdata = i_rdata_q;
      d_dfp_rdata = d_rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= '0;
         last_grant <= ICACHE;
         owner      <= ICACHE;
         addr_q     <= '0;
         line_buf   <= '0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  owner      <= pick_d;
                  last_grant <= pick_d;
                  addr_q     <= sel_addr;
                  if (go_write) begin
                     count <= CW'(1);
                     state <= WR_BURST;
                  end else begin
                     count <= '0;
                     state <= RD_WAIT;
                  end
               end
            end
            WR_BURST: begin
               if (bmem_ready) begin
                  count <= count + 1'b1;
                  if (count == LAST_BEAT)
                     state <= RESP;
               end
            end
            RD_WAIT: begin
               // The client's rdata register is loaded with the completed line so it
               // is valid during RESP and holds until that client's next read.
               if (bmem_rvalid) begin
                  line_buf <= line_next;
                  count    <= count + 1'b1;
                  if (count == LAST_BEAT) begin
                     state <= RESP;
                     if (owner == DCACHE)
                        d_rdata_q <= line_next;
                     else
                        i_rdata_q <= line_next;
                  end
               end
            end
            RESP: begin
               count <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(d_dfp_read && d_dfp_write));
         assert (!bmem_rvalid || (state == RD_WAIT));
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter : scoreboard bench with a burst-memory responder model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;
   localparam int LW = 256;
   localparam int BW = 64;
   localparam int BL = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   i_dfp_addr = '0;
   logic          i_dfp_read = 1'b0;
   logic [LW-1:0] i_dfp_rdata;
   logic          i_dfp_resp;
   logic [31:0]   d_dfp_addr = '0;
   logic          d_dfp_read = 1'b0;
   logic          d_dfp_write = 1'b0;
   logic [LW-1:0] d_dfp_wdata = '0;
   logic [LW-1:0] d_dfp_rdata;
   logic          d_dfp_resp;
   logic [31:0]   bmem_addr;
   logic          bmem_read;
   logic          bmem_write;
   logic [BW-1:0] bmem_wdata;
   logic          bmem_ready = 1'b1;
   logic [BW-1:0] bmem_rdata = '0;
   logic          bmem_rvalid = 1'b0;

   cache_mem_arbiter #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW), .BURST_LEN(BL)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read),
      .i_dfp_rdata(i_dfp_rdata), .i_dfp_resp(i_dfp_resp),
      .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
      .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(d_dfp_rdata), .d_dfp_resp(d_dfp_resp),
      .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
      .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
      .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          is_d;
      logic          is_wr;
      logic [LW-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   logic [31:0]   cmd_q[$];
   logic [BW-1:0] wbeat_q[$];

   int checks = 0;
   int errors = 0;

   // request bookkeeping: main process owns *_total, monitor owns *_done
   int          i_total = 0, i_done = 0, d_total = 0, d_done = 0;
   logic        d_wr_mode = 1'b0;
   logic [31:0] wr_addr_exp = '0;
   logic [LW-1:0] wline;

   int          cyc = 0, last_beat_cyc = 0, beats_left = 0, gap = 0;
   logic [31:0] rsp_addr = '0;

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [BW-1:0] beat_of(input logic [31:0] a, input int k);
      return {a, 8'hA5, 16'h5A00, 8'(k)};
   endfunction

   function automatic logic [LW-1:0] line_of(input logic [31:0] a);
      logic [LW-1:0] l;
      l = '0;
      for (int k = 0; k < BL; k++) l[k*BW +: BW] = beat_of(a, k);
      return l;
   endfunction

   task automatic push_exp(input logic is_d, input logic is_wr, input logic [LW-1:0] data);
      exp_t e;
      e.is_d = is_d; e.is_wr = is_wr; e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || beats_left != 0) && n < 300) begin
         @(posedge clk);
         n++;
      end
      check(tag, exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctl"}, {i_dfp_resp, d_dfp_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata}, '0);
      check({tag, "_irdata"}, i_dfp_rdata, '0);
      check({tag, "_drdata"}, d_dfp_rdata, '0);
   endtask

   // Monitor, request driver and memory responder, all on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n && (i_dfp_resp || d_dfp_resp)) begin
            check("resp_onehot", {i_dfp_resp, d_dfp_resp} != 2'b11, 1);
            check("resp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("resp_client", d_dfp_resp, e.is_d);
               check("resp_latency", cyc, last_beat_cyc + 1);
               if (!e.is_wr) check("resp_rdata", e.is_d ? d_dfp_rdata : i_dfp_rdata, e.data);
               if (e.is_d) d_done++; else i_done++;
            end
         end
         i_dfp_read  = (i_done < i_total);
         d_dfp_read  = (d_done < d_total) && !d_wr_mode;
         d_dfp_write = (d_done < d_total) && d_wr_mode;
         bmem_rvalid = 1'b0;
         if (beats_left > 0) begin
            if (gap > 0) gap--;
            else begin
               bmem_rvalid   = 1'b1;
               bmem_rdata    = beat_of(rsp_addr, BL - beats_left);
               beats_left--;
               last_beat_cyc = cyc;
            end
         end
         #1;
         if (rst_n && bmem_read) begin
            check("cmd_when_ready", bmem_ready, 1);
            check("cmd_expected", cmd_q.size() != 0, 1);
            if (cmd_q.size() != 0) check("cmd_addr", bmem_addr, cmd_q.pop_front());
            rsp_addr   = bmem_addr;
            beats_left = BL;
            gap        = 1;
         end
         if (rst_n && bmem_write && bmem_ready) begin
            check("wr_expected", wbeat_q.size() != 0, 1);
            if (wbeat_q.size() != 0) check("wr_beat", bmem_wdata, wbeat_q.pop_front());
            check("wr_addr", bmem_addr, wr_addr_exp);
            last_beat_cyc = cyc;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("reset");
      rst_n = 1'b1;

      // icache line read with address offset bits set
      @(posedge clk); #1;
      i_dfp_addr = 32'h0000_1044;
      cmd_q.push_back(32'h0000_1040);
      push_exp(1'b0, 1'b0, line_of(32'h0000_1040));
      i_total++;
      wait_done("t1_done");

      // dcache writeback with one ready stall after beat 0
      wline = 256'h3333_3333_DDDD_DDDD_2222_2222_CCCC_CCCC_1111_1111_BBBB_BBBB_0000_0000_AAAA_AAAA;
      d_dfp_wdata = wline;
      d_dfp_addr  = 32'h0000_2000;
      wr_addr_exp = 32'h0000_2000;
      d_wr_mode   = 1'b1;
      for (int k = 0; k < BL; k++) wbeat_q.push_back(wline[k*BW +: BW]);
      push_exp(1'b1, 1'b1, '0);
      d_total++;
      @(posedge clk); #1 bmem_ready = 1'b0;
      #1;
      check("t2_hold_write", bmem_write, 1);
      check("t2_hold_beat", bmem_wdata, wline[127:64]);
      @(posedge clk); #1 bmem_ready = 1'b1;
      wait_done("t2_done");
      check("t2_all_beats", wbeat_q.size(), 0);
      d_wr_mode = 1'b0;

      // simultaneous reads straight out of reset: dcache first
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      i_dfp_addr = 32'h0000_5004;
      d_dfp_addr = 32'h0000_6008;
      cmd_q.push_back(32'h0000_6000); push_exp(1'b1, 1'b0, line_of(32'h0000_6000));
      cmd_q.push_back(32'h0000_5000); push_exp(1'b0, 1'b0, line_of(32'h0000_5000));
      i_total++; d_total++;
      wait_done("t3_done");

      // continuous contention: D, I, D, I
      i_dfp_addr = 32'h0000_7000;
      d_dfp_addr = 32'h0000_8000;
      for (int k = 0; k < 2; k++) begin
         cmd_q.push_back(32'h0000_8000); push_exp(1'b1, 1'b0, line_of(32'h0000_8000));
         cmd_q.push_back(32'h0000_7000); push_exp(1'b0, 1'b0, line_of(32'h0000_7000));
      end
      i_total += 2; d_total += 2;
      wait_done("t4_done");

      // memory not ready: no command until ready rises
      bmem_ready = 1'b0;
      i_dfp_addr = 32'h0000_9010;
      cmd_q.push_back(32'h0000_9000); push_exp(1'b0, 1'b0, line_of(32'h0000_9000));
      i_total++;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("t5_no_cmd", {bmem_read, bmem_write, bmem_addr}, '0);
      end
      bmem_ready = 1'b1;
      #1;
      check("t5_cmd_on_ready", bmem_read, 1);
      check("t5_cmd_addr", bmem_addr, 32'h0000_9000);
      wait_done("t5_done");

      // reset after two read beats
      i_dfp_addr = 32'h0000_3000;
      cmd_q.push_back(32'h0000_3000); push_exp(1'b0, 1'b0, line_of(32'h0000_3000));
      i_total++;
      n = 0;
      while (beats_left != 2 && n < 50) begin
         @(posedge clk);
         n++;
      end
      check("t6_two_beats", beats_left, 2);
      #1 rst_n = 1'b0;
      exp_q.delete();
      i_total--;
      #1 check_reset_outputs("t6_reset");
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b1;
      check("t6_beats_drained", beats_left, 0);
      repeat (3) @(posedge clk);
      #1 check("t6_no_resp_after", exp_q.size(), 0);
      i_dfp_addr = 32'h0000_A000;
      cmd_q.push_back(32'h0000_A000); push_exp(1'b0, 1'b0, line_of(32'h0000_A000));
      i_total++;
      wait_done("t6_fresh_done");

      repeat (3) @(posedge clk);
      check("cmd_queue_empty", cmd_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
